wb_timer_pwm: RTL

Wishbone timer/PWM peripheral for the unused slave 2 slot of the user-area interconnect. It sits directly downstream of the interconnect, alongside the SRAM, UART and SPI slaves. It provides:
- a prescaled up-counter with a programmable period;
- one-shot or continuous mode;
- a PWM output on a user GPIO pad;
- a level interrupt to the management SoC.

---
 rtl/wb_timer_pkg.sv | 37 +++
 rtl/wb_timer_core.sv | 65 ++++++
 rtl/wb_timer_pwm.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer/PWM peripheral: register map,
// CTRL bit positions, the CTRL register layout and a byte-lane merge helper.
package wb_timer_pkg;

  localparam logic [2:0] ADR_CTRL     = 3'd0;
  localparam logic [2:0] ADR_PRESCALE = 3'd1;
  localparam logic [2:0] ADR_PERIOD   = 3'd2;
  localparam logic [2:0] ADR_DUTY     = 3'd3;
  localparam logic [2:0] ADR_COUNT    = 3'd4;
  localparam logic [2:0] ADR_STATUS   = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_PWM_EN  = 3;
  localparam int CTRL_PWM_POL = 4;

  // Field order makes en land on bit 0, matching the register layout.
  typedef struct packed {
    logic pwm_pol;
    logic pwm_en;
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_t;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_timer_core.sv
// Timer datapath: prescaler, up-counter with terminal count, sticky match
// flag and the registered PWM / interrupt outputs.
module wb_timer_core
  import wb_timer_pkg::*;
#(
  parameter int CNT_WD = 32,
  parameter int PRE_WD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  ctrl_t             ctrl,
  input  logic [PRE_WD-1:0] prescale,
  input  logic [CNT_WD-1:0] period,
  input  logic [CNT_WD-1:0] duty,
  input  logic              cnt_wr,
  input  logic [CNT_WD-1:0] cnt_wdata,
  input  logic              match_clr,
  output logic [CNT_WD-1:0] count,
  output logic              match,
  output logic              stop,
  output logic              pwm,
  output logic              irq
);

  logic [PRE_WD-1:0] pre_cnt;
  logic              tick;
  logic              wrap;

  assign tick = ctrl.en && (pre_cnt == prescale);
  // >= rather than == so a PERIOD written below COUNT wraps on the next tick.
  assign wrap = tick && (count >= period);
  assign stop = wrap && ctrl.oneshot;

  // Prescaler: free-runs 0..PRESCALE while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || !ctrl.en || tick) pre_cnt <= '0;
    else                         pre_cnt <= pre_cnt + PRE_WD'(1);
  end

  // Counter: a bus load takes priority over the tick update.
  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (cnt_wr) count <= cnt_wdata;
    else if (tick)   count <= wrap ? '0 : count + CNT_WD'(1);
  end

  // Sticky match: a new match beats a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (rst)            match <= 1'b0;
    else if (wrap)      match <= 1'b1;
    else if (match_clr) match <= 1'b0;
  end

  // Registered outputs, one clock behind their source state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
      irq <= 1'b0;
    end else begin
      pwm <= ctrl.pwm_pol ^ (ctrl.pwm_en & ctrl.en & (count < duty));
      irq <= match & ctrl.irq_en;
    end
  end

endmodule

// File: rtl/wb_timer_pwm.sv
// Wishbone timer/PWM slave: register file, single-cycle ack generation and
// read mux around the timer core.
module wb_timer_pwm
  import wb_timer_pkg::*;
#(
  parameter int CNT_WD = 32,
  parameter int PRE_WD = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        pwm_o,
  output logic        irq_o
);

  ctrl_t             ctrl;
  logic [PRE_WD-1:0] prescale;
  logic [CNT_WD-1:0] period;
  logic [CNT_WD-1:0] duty;
  logic [CNT_WD-1:0] count;
  logic              match;
  logic              stop;

  logic              access;
  logic              wr;
  logic              cnt_wr;
  logic              match_clr;
  logic [31:0]       rd_mux;
  logic [31:0]       wmerge;

  assign access = wb_cyc_i & wb_stb_i;
  // Commit on the ack cycle's edge so an access abandoned before ack writes nothing.
  assign wr        = access & wb_we_i & wb_ack_o;
  assign cnt_wr    = wr && (wb_adr_i == ADR_COUNT);
  assign match_clr = wr && (wb_adr_i == ADR_STATUS) && wb_sel_i[0] && wb_dat_i[0];
  assign wmerge    = merge_lanes(rd_mux, wb_dat_i, wb_sel_i);

  // Read mux: registers zero-extended to 32 bits, unmapped addresses read 0.
  always_comb begin
    rd_mux = '0;
    case (wb_adr_i)
      ADR_CTRL:     rd_mux[$bits(ctrl_t)-1:0] = ctrl;
      ADR_PRESCALE: rd_mux[PRE_WD-1:0]        = prescale;
      ADR_PERIOD:   rd_mux[CNT_WD-1:0]        = period;
      ADR_DUTY:     rd_mux[CNT_WD-1:0]        = duty;
      ADR_COUNT:    rd_mux[CNT_WD-1:0]        = count;
      ADR_STATUS:   rd_mux[1:0]               = {ctrl.en, match};
      default:      rd_mux = '0;
    endcase
  end

  // Ack pulses once per access and forces a low cycle before the next one.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access & ~wb_ack_o;
      wb_dat_o <= (access & ~wb_ack_o & ~wb_we_i) ? rd_mux : '0;
    end
  end

  // Register file; a bus write to CTRL overrides the one-shot EN clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl     <= '0;
      prescale <= '0;
      period   <= '0;
      duty     <= '0;
    end else begin
      if (wr) begin
        case (wb_adr_i)
          ADR_PRESCALE: prescale <= wmerge[PRE_WD-1:0];
          ADR_PERIOD:   period   <= wmerge[CNT_WD-1:0];
          ADR_DUTY:     duty     <= wmerge[CNT_WD-1:0];
          default: ;
        endcase
      end
      if (wr && (wb_adr_i == ADR_CTRL)) begin
        ctrl <= '{pwm_pol: wmerge[CTRL_PWM_POL],
                  pwm_en:  wmerge[CTRL_PWM_EN],
                  irq_en:  wmerge[CTRL_IRQ_EN],
                  oneshot: wmerge[CTRL_ONESHOT],
                  en:      wmerge[CTRL_EN]};
      end else if (stop) begin
        ctrl.en <= 1'b0;
      end
    end
  end

  wb_timer_core #(
    .CNT_WD (CNT_WD),
    .PRE_WD (PRE_WD)
  ) u_core (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .ctrl      (ctrl),
    .prescale  (prescale),
    .period    (period),
    .duty      (duty),
    .cnt_wr    (cnt_wr),
    .cnt_wdata (wmerge[CNT_WD-1:0]),
    .match_clr (match_clr),
    .count     (count),
    .match     (match),
    .stop      (stop),
    .pwm       (pwm_o),
    .irq       (irq_o)
  );

endmodule
